// File: rtl/song_writer.sv
// Converts live note events into packed note/wait song words and streams them
// to the song RAM write port, one entry per write cycle, 128 entries per take.
module song_writer #(
    parameter int SONG_WIDTH     = 7,
    parameter int NOTE_WIDTH     = 6,
    parameter int DURATION_WIDTH = 6,
    parameter int METADATA       = 3
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       record,
    input  logic [1:0]                                 song,
    input  logic                                       beat,
    input  logic                                       note_valid,
    input  logic [NOTE_WIDTH-1:0]                      note,
    input  logic [DURATION_WIDTH-1:0]                  duration,
    output logic                                       note_ready,
    output logic                                       wr_en,
    output logic [SONG_WIDTH+1:0]                      wr_addr,
    output logic [NOTE_WIDTH+DURATION_WIDTH+METADATA:0] wr_data,
    output logic                                       recording,
    output logic                                       song_full,
    output logic [SONG_WIDTH:0]                        entry_count
);

    localparam int REC_W  = 1 + NOTE_WIDTH + DURATION_WIDTH + METADATA;
    localparam int ADDR_W = 2 + SONG_WIDTH;

    localparam logic [DURATION_WIDTH-1:0] MAX_GAP    = '1;
    localparam logic [SONG_WIDTH:0]       LAST_ENTRY = {1'b0, {SONG_WIDTH{1'b1}}};
    localparam logic [SONG_WIDTH:0]       ONE_ENTRY  = {{SONG_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_WRITE_WAIT,
        S_WRITE_NOTE,
        S_FULL
    } state_t;

    state_t                       r_state;
    logic [1:0]                   r_song;
    logic [SONG_WIDTH:0]          r_entry_count;
    logic [DURATION_WIDTH-1:0]    r_gap;
    logic                         r_pending;
    logic                         r_stop;
    logic [NOTE_WIDTH-1:0]        r_note;
    logic [DURATION_WIDTH-1:0]    r_dur;
    logic                         r_wr_en;
    logic [ADDR_W-1:0]            r_wr_addr;
    logic [REC_W-1:0]             r_wr_data;
    logic                         r_note_ready;
    logic                         r_recording;
    logic                         r_song_full;

    logic [DURATION_WIDTH-1:0]    w_beat_inc;
    logic [DURATION_WIDTH-1:0]    w_gap_next;
    logic [SONG_WIDTH:0]          w_entry_inc;
    logic [ADDR_W-1:0]            w_addr_cur;
    logic [ADDR_W-1:0]            w_addr_inc;
    logic                         w_last_entry;

    function automatic logic [REC_W-1:0] f_note_rec(input logic [NOTE_WIDTH-1:0]     n,
                                                     input logic [DURATION_WIDTH-1:0] d);
        return {1'b0, n, d, {METADATA{1'b0}}};
    endfunction

    function automatic logic [REC_W-1:0] f_wait_rec(input logic [DURATION_WIDTH-1:0] g);
        return {1'b1, {NOTE_WIDTH{1'b0}}, g, {METADATA{1'b0}}};
    endfunction

    assign w_beat_inc   = {{(DURATION_WIDTH-1){1'b0}}, beat};
    assign w_gap_next   = r_gap + w_beat_inc;
    assign w_entry_inc  = r_entry_count + ONE_ENTRY;
    assign w_addr_cur   = {r_song, r_entry_count[SONG_WIDTH-1:0]};
    assign w_addr_inc   = {r_song, w_entry_inc[SONG_WIDTH-1:0]};
    assign w_last_entry = (r_entry_count == LAST_ENTRY);

    // Write outputs are loaded on the transition into a write state, so each
    // write state presents its record for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_song        <= '0;
            r_entry_count <= '0;
            r_gap         <= '0;
            r_pending     <= 1'b0;
            r_stop        <= 1'b0;
            r_note        <= '0;
            r_dur         <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_note_ready  <= 1'b0;
            r_recording   <= 1'b0;
            r_song_full   <= 1'b0;
        end else begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            case (r_state)
                S_IDLE: begin
                    if (record) begin
                        r_state       <= S_ARMED;
                        r_song        <= song;
                        r_entry_count <= '0;
                        r_gap         <= '0;
                        r_pending     <= 1'b0;
                        r_stop        <= 1'b0;
                        r_note_ready  <= 1'b1;
                        r_recording   <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (!record) begin
                        r_state      <= S_IDLE;
                        r_note_ready <= 1'b0;
                        r_recording  <= 1'b0;
                    end else if (note_valid) begin
                        r_state      <= S_WRITE_NOTE;
                        r_note_ready <= 1'b0;
                        r_wr_en      <= 1'b1;
                        r_wr_addr    <= w_addr_cur;
                        r_wr_data    <= f_note_rec(note, duration);
                    end
                end
                S_CAPTURE: begin
                    r_gap <= w_gap_next;
                    if (!record) begin
                        r_note_ready <= 1'b0;
                        if (w_gap_next != '0) begin
                            r_state   <= S_WRITE_WAIT;
                            r_stop    <= 1'b1;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_addr_cur;
                            r_wr_data <= f_wait_rec(w_gap_next);
                        end else begin
                            r_state     <= S_IDLE;
                            r_recording <= 1'b0;
                        end
                    end else if (note_valid) begin
                        r_note_ready <= 1'b0;
                        r_wr_en      <= 1'b1;
                        r_wr_addr    <= w_addr_cur;
                        if (w_gap_next != '0) begin
                            r_state   <= S_WRITE_WAIT;
                            r_pending <= 1'b1;
                            r_note    <= note;
                            r_dur     <= duration;
                            r_wr_data <= f_wait_rec(w_gap_next);
                        end else begin
                            r_state   <= S_WRITE_NOTE;
                            r_wr_data <= f_note_rec(note, duration);
                        end
                    end else if (w_gap_next == MAX_GAP) begin
                        r_state      <= S_WRITE_WAIT;
                        r_note_ready <= 1'b0;
                        r_wr_en      <= 1'b1;
                        r_wr_addr    <= w_addr_cur;
                        r_wr_data    <= f_wait_rec(w_gap_next);
                    end
                end
                S_WRITE_WAIT: begin
                    r_entry_count <= w_entry_inc;
                    r_gap         <= w_beat_inc;
                    if (w_last_entry) begin
                        r_state     <= S_FULL;
                        r_song_full <= 1'b1;
                        r_pending   <= 1'b0;
                        r_stop      <= 1'b0;
                    end else if (r_pending) begin
                        r_state   <= S_WRITE_NOTE;
                        r_pending <= 1'b0;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_addr_inc;
                        r_wr_data <= f_note_rec(r_note, r_dur);
                    end else if (r_stop || !record) begin
                        r_state     <= S_IDLE;
                        r_stop      <= 1'b0;
                        r_recording <= 1'b0;
                    end else begin
                        r_state      <= S_CAPTURE;
                        r_note_ready <= 1'b1;
                    end
                end
                S_WRITE_NOTE: begin
                    r_entry_count <= w_entry_inc;
                    r_gap         <= w_gap_next;
                    if (w_last_entry) begin
                        r_state     <= S_FULL;
                        r_song_full <= 1'b1;
                    end else if (!record) begin
                        r_state     <= S_IDLE;
                        r_recording <= 1'b0;
                    end else begin
                        r_state      <= S_CAPTURE;
                        r_note_ready <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (!record) begin
                        r_state     <= S_IDLE;
                        r_song_full <= 1'b0;
                        r_recording <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_note_ready <= 1'b0;
                    r_recording  <= 1'b0;
                    r_song_full  <= 1'b0;
                end
            endcase
        end
    end

    assign note_ready  = r_note_ready;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign recording   = r_recording;
    assign song_full   = r_song_full;
    assign entry_count = r_entry_count;

endmodule

// File: tb/tb_song_writer.sv
// Bench for song_writer: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a queue-based model of the recorder.
module tb_song_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       record = 1'b0;
    logic [1:0] song = '0;
    logic       beat = 1'b0;
    logic       note_valid = 1'b0;
    logic [5:0] note = '0;
    logic [5:0] duration = '0;
    logic       note_ready, wr_en, recording, song_full;
    logic [8:0] wr_addr;
    logic [15:0] wr_data;
    logic [7:0] entry_count;
    logic [36:0] dut_vec;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    song_writer #(
        .SONG_WIDTH(7),
        .NOTE_WIDTH(6),
        .DURATION_WIDTH(6),
        .METADATA(3)
    ) dut (
        .clk(clk), .reset(reset), .record(record), .song(song), .beat(beat),
        .note_valid(note_valid), .note(note), .duration(duration),
        .note_ready(note_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .recording(recording), .song_full(song_full), .entry_count(entry_count)
    );

    assign dut_vec = {wr_en, wr_addr, wr_data, recording, song_full, note_ready, entry_count};

    // Reference model: a take is a mode plus a queue of song words still to be
    // written; the head of the queue is the word on the RAM port this cycle.
    typedef enum {M_IDLE, M_ARMED, M_CAPTURE, M_FULL} mmode_t;
    mmode_t      m_mode = M_IDLE;
    int          m_gap = 0;
    int          m_count = 0;
    int          m_song = 0;
    bit          m_stop = 0;
    logic [15:0] m_q[$];

    function automatic logic [15:0] wait_word(input int g);
        return 16'(32768 + g * 8);
    endfunction

    function automatic logic [15:0] note_word(input int n, input int d);
        return 16'(n * 512 + d * 8);
    endfunction

    function automatic void model_step();
        int g2;
        logic [15:0] cur;
        if (reset) begin
            m_mode = M_IDLE; m_gap = 0; m_count = 0; m_song = 0; m_stop = 0;
            m_q.delete();
            return;
        end
        if (m_q.size() != 0) begin
            cur = m_q.pop_front();
            m_count++;
            m_gap = cur[15] ? int'(beat) : m_gap + int'(beat);
            if (m_count == 128) begin
                m_mode = M_FULL; m_stop = 0;
                m_q.delete();
            end else if (m_q.size() != 0) begin
                m_mode = M_CAPTURE;
            end else if (m_stop || !record) begin
                m_mode = M_IDLE; m_stop = 0;
            end else begin
                m_mode = M_CAPTURE;
            end
            return;
        end
        case (m_mode)
            M_IDLE: if (record) begin
                m_mode = M_ARMED; m_song = int'(song); m_count = 0; m_gap = 0; m_stop = 0;
            end
            M_ARMED: begin
                if (!record) m_mode = M_IDLE;
                else if (note_valid) begin
                    m_q.push_back(note_word(int'(note), int'(duration)));
                    m_mode = M_CAPTURE;
                end
            end
            M_CAPTURE: begin
                g2 = m_gap + int'(beat);
                if (!record) begin
                    if (g2 > 0) begin
                        m_q.push_back(wait_word(g2));
                        m_stop = 1;
                    end else m_mode = M_IDLE;
                end else if (note_valid) begin
                    if (g2 > 0) m_q.push_back(wait_word(g2));
                    m_q.push_back(note_word(int'(note), int'(duration)));
                end else if (g2 == 63) begin
                    m_q.push_back(wait_word(63));
                end
                m_gap = g2;
            end
            M_FULL: if (!record) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
    endfunction

    function automatic logic [36:0] exp_vec();
        logic busy;
        logic [8:0] a;
        logic [15:0] d;
        busy = (m_q.size() != 0);
        a = busy ? 9'(m_song * 128 + m_count) : 9'd0;
        d = busy ? m_q[0] : 16'd0;
        return {busy, a, d, m_mode != M_IDLE, m_mode == M_FULL,
                !busy && (m_mode == M_ARMED || m_mode == M_CAPTURE), 8'(m_count)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (dut_vec !== 37'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec, 37'd0);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec());
        end
        reset = 1'b0;
    endtask

    task automatic test_first_note();
        song = 2'd2; record = 1'b1;
        tick();
        checks++;
        if (dut_vec !== exp_vec() || note_ready !== 1'b1) begin
            fails++;
            $display("FAIL armed: got %h expected %h", dut_vec, exp_vec());
        end
        note_valid = 1'b1; note = 6'd20; duration = 6'd12;
        tick();
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 9'h100 || wr_data !== 16'h2860) begin
            fails++;
            $display("FAIL first_note_write: got en=%b addr=%h data=%h expected en=1 addr=100 data=2860",
                     wr_en, wr_addr, wr_data);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL first_note_model: got %h expected %h", dut_vec, exp_vec());
        end
        note_valid = 1'b0;
        tick();
        checks++;
        if (entry_count !== 8'd1 || wr_en !== 1'b0) begin
            fails++;
            $display("FAIL first_note_count: got count=%0d en=%b expected count=1 en=0", entry_count, wr_en);
        end
    endtask

    task automatic test_wait_gap();
        beat = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL gap_beats: got %h expected %h", dut_vec, exp_vec());
            end
        end
        beat = 1'b0; note_valid = 1'b1; note = 6'd20; duration = 6'd12;
        tick();
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 9'h101 || wr_data !== 16'h8028) begin
            fails++;
            $display("FAIL wait_record: got addr=%h data=%h expected addr=101 data=8028", wr_addr, wr_data);
        end
        note_valid = 1'b0;
        tick();
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 9'h102 || wr_data !== 16'h2860) begin
            fails++;
            $display("FAIL note_after_wait: got addr=%h data=%h expected addr=102 data=2860", wr_addr, wr_data);
        end
        tick();
        checks++;
        if (dut_vec !== exp_vec() || entry_count !== 8'd3) begin
            fails++;
            $display("FAIL after_wait_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] first_addr;
        note_valid = 1'b1; note = 6'd7; duration = 6'd3;
        tick();
        first_addr = wr_addr;
        checks++;
        if (wr_en !== 1'b1 || wr_data !== note_word(7, 3) || dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL chord_first: got %h expected %h", dut_vec, exp_vec());
        end
        note = 6'd9; duration = 6'd4;
        tick();
        checks++;
        if (wr_en !== 1'b0 || dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL chord_gap_cycle: got %h expected %h", dut_vec, exp_vec());
        end
        tick();
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== first_addr + 9'd1 || wr_data !== note_word(9, 4)) begin
            fails++;
            $display("FAIL chord_second: got addr=%h data=%h expected addr=%h data=%h",
                     wr_addr, wr_data, first_addr + 9'd1, note_word(9, 4));
        end
        note_valid = 1'b0;
        tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL chord_done: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_long_silence();
        logic [15:0] seen[$];
        int first_at = -1;
        beat = 1'b1;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (wr_en) begin
                seen.push_back(wr_data);
                if (first_at < 0) first_at = i;
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL silence_cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        beat = 1'b0; note_valid = 1'b1; note = 6'd20; duration = 6'd12;
        for (int i = 0; i < 3; i++) begin
            tick();
            note_valid = 1'b0;
            if (wr_en) seen.push_back(wr_data);
        end
        checks++;
        if (first_at != 62) begin
            fails++;
            $display("FAIL silence_flush_beat: got beat %0d expected beat 63", first_at + 1);
        end
        checks++;
        if (seen.size() != 3 || seen[0] !== 16'h81F8 || seen[1] !== 16'h8038 || seen[2] !== 16'h2860) begin
            fails++;
            $display("FAIL silence_records: got %0d writes first %h expected 81F8,8038,2860",
                     seen.size(), (seen.size() != 0) ? seen[0] : 16'h0);
        end
        record = 1'b0;
        tick();
        checks++;
        if (recording !== 1'b0 || dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL stop_take: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_fill();
        int writes = 0;
        record = 1'b1; song = 2'd1;
        tick();
        note_valid = 1'b1;
        for (int c = 0; c < 600 && !song_full; c++) begin
            note = 6'($urandom); duration = 6'($urandom);
            tick();
            if (wr_en) writes++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL fill_cycle %0d: got %h expected %h", c, dut_vec, exp_vec());
            end
        end
        checks++;
        if (song_full !== 1'b1 || note_ready !== 1'b0 || writes != 128 || entry_count !== 8'd128) begin
            fails++;
            $display("FAIL fill_full: got full=%b ready=%b writes=%0d count=%0d expected 1 0 128 128",
                     song_full, note_ready, writes, entry_count);
        end
        tick();
        checks++;
        if (wr_en !== 1'b0 || song_full !== 1'b1) begin
            fails++;
            $display("FAIL fill_extra_note: got en=%b full=%b expected en=0 full=1", wr_en, song_full);
        end
        record = 1'b0; note_valid = 1'b0;
        tick();
        checks++;
        if (song_full !== 1'b0 || recording !== 1'b0 || dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL fill_release: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_reset_mid_write();
        record = 1'b1;
        tick();
        note_valid = 1'b1; note = 6'd5; duration = 6'd2;
        tick();
        note_valid = 1'b0;
        tick();
        beat = 1'b1;
        repeat (3) tick();
        beat = 1'b0; note_valid = 1'b1;
        tick();
        checks++;
        if (wr_en !== 1'b1 || wr_data !== 16'h8018) begin
            fails++;
            $display("FAIL pre_reset_wait: got en=%b data=%h expected en=1 data=8018", wr_en, wr_data);
        end
        reset = 1'b1; note_valid = 1'b0;
        tick();
        checks++;
        if (wr_en !== 1'b0 || entry_count !== 8'd0 || recording !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_write: got en=%b count=%0d rec=%b expected 0 0 0",
                     wr_en, entry_count, recording);
        end
        reset = 1'b0; record = 1'b0;
        tick();
        checks++;
        if (wr_en !== 1'b0 || dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL after_reset_no_note: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        bit sparse;
        for (int c = 0; c < 3000; c++) begin
            sparse = ((c / 300) % 2) == 1;
            reset = ($urandom_range(0, 499) == 0);
            if (record) record = sparse ? ($urandom_range(0, 399) != 0) : ($urandom_range(0, 59) != 0);
            else        record = ($urandom_range(0, 4) == 0);
            beat       = sparse ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            note_valid = sparse ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 2) == 0);
            note = 6'($urandom); duration = 6'($urandom); song = 2'($urandom);
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL random_cycle %0d: got %h expected %h", c, dut_vec, exp_vec());
            end
        end
        reset = 1'b0; record = 1'b0; beat = 1'b0; note_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_wait_gap();
        test_back_to_back();
        test_long_silence();
        test_fill();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
